// File: rtl/pipe_skid_reg_if.sv
// Stage-boundary bundle for pipe_skid_reg: upstream entry, downstream entry,
// occupancy and statistics. The DUT uses the slave modport, the producer side uses master.
interface pipe_skid_reg_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned WB_W   = 2,
  parameter int unsigned OP_W   = 6,
  parameter int unsigned CNT_W  = 16
);
  logic              i_valid;
  logic              o_ready;
  logic [RD_W-1:0]   i_rd;
  logic [WB_W-1:0]   i_wb;
  logic [DATA_W-1:0] i_data;
  logic [OP_W-1:0]   i_operation;
  logic              i_flush;
  logic              o_valid;
  logic              i_ready;
  logic [RD_W-1:0]   o_rd;
  logic [WB_W-1:0]   o_wb;
  logic [DATA_W-1:0] o_data;
  logic [OP_W-1:0]   o_operation;
  logic [1:0]        o_count;
  logic [CNT_W-1:0]  o_stall_cnt;
  logic [CNT_W-1:0]  o_bubble_cnt;

  modport slave (
    input  i_valid, i_rd, i_wb, i_data, i_operation, i_flush, i_ready,
    output o_ready, o_valid, o_rd, o_wb, o_data, o_operation, o_count,
    output o_stall_cnt, o_bubble_cnt
  );

  modport master (
    output i_valid, i_rd, i_wb, i_data, i_operation, i_flush, i_ready,
    input  o_ready, o_valid, o_rd, o_wb, o_data, o_operation, o_count,
    input  o_stall_cnt, o_bubble_cnt
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid buffer,
// flush and NOP-bubble outputs. Statistics counters enabled by PIPE_SKID_REG_STATS_EN.
module pipe_skid_reg #(
  parameter int unsigned    DATA_W = 32,
  parameter int unsigned    RD_W   = 5,
  parameter int unsigned    WB_W   = 2,
  parameter int unsigned    OP_W   = 6,
  parameter logic [OP_W-1:0] NOP_OP = '1,
  parameter int unsigned    CNT_W  = 16
) (
  input logic clk,
  input logic rst,
  pipe_skid_reg_if.slave bus
);

  logic              main_valid, skid_valid, ready_q;
  logic [1:0]        count_q;
  logic [RD_W-1:0]   main_rd,   skid_rd;
  logic [WB_W-1:0]   main_wb,   skid_wb;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [OP_W-1:0]   main_op,   skid_op;
  logic              accept, drain;

  assign accept = bus.i_valid & ready_q;
  assign drain  = main_valid & bus.i_ready;

  // Main payload is forced to bubble values whenever main goes empty,
  // so the outputs can be driven straight from the main flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
      count_q    <= 2'd0;
      main_rd    <= '0;
      main_wb    <= '0;
      main_data  <= '0;
      main_op    <= NOP_OP;
      skid_rd    <= '0;
      skid_wb    <= '0;
      skid_data  <= '0;
      skid_op    <= '0;
    end else if (bus.i_flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
      count_q    <= 2'd0;
      main_rd    <= '0;
      main_wb    <= '0;
      main_data  <= '0;
      main_op    <= NOP_OP;
    end else if (!main_valid || drain) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_rd    <= skid_rd;
        main_wb    <= skid_wb;
        main_data  <= skid_data;
        main_op    <= skid_op;
        skid_valid <= 1'b0;
        ready_q    <= 1'b1;
        count_q    <= 2'd1;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_rd    <= bus.i_rd;
        main_wb    <= bus.i_wb;
        main_data  <= bus.i_data;
        main_op    <= bus.i_operation;
        count_q    <= 2'd1;
      end else begin
        main_valid <= 1'b0;
        main_rd    <= '0;
        main_wb    <= '0;
        main_data  <= '0;
        main_op    <= NOP_OP;
        count_q    <= 2'd0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_rd    <= bus.i_rd;
      skid_wb    <= bus.i_wb;
      skid_data  <= bus.i_data;
      skid_op    <= bus.i_operation;
      ready_q    <= 1'b0;
      count_q    <= 2'd2;
    end
  end

  assign bus.o_valid     = main_valid;
  assign bus.o_ready     = ready_q;
  assign bus.o_count     = count_q;
  assign bus.o_rd        = main_rd;
  assign bus.o_wb        = main_wb;
  assign bus.o_data      = main_data;
  assign bus.o_operation = main_op;

`ifdef PIPE_SKID_REG_STATS_EN
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;

  // Saturating counters; flush intentionally does not clear them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (main_valid && !bus.i_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (!main_valid && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign bus.o_stall_cnt  = stall_cnt;
  assign bus.o_bubble_cnt = bubble_cnt;
`else
  assign bus.o_stall_cnt  = '0;
  assign bus.o_bubble_cnt = '0;
`endif

endmodule
